// File: rtl/spi_master_pkg.sv
// Shared types and constants for the SPI master.
package spi_master_pkg;

    // Transfer sequencing states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } stateT;

    // Bits per transfer, MSB first.
    localparam int BIT_COUNT = 8;

    // Index of the final sclk transition within SHIFT (two per bit).
    localparam logic [3:0] LAST_EDGE = 4'(2 * BIT_COUNT - 1);

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period tick generator: one tick every CLK_DIV enabled cycles.
// The counter restarts from zero whenever the enable drops, so each
// transfer begins on a clean phase.
module spi_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);
    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = en && (cnt == CNT_MAX);

    // Free-running count while enabled, wrapping at CLK_DIV-1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                      cnt <= '0;
        else if (!en || cnt == CNT_MAX) cnt <= '0;
        else                            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/spi_master.sv
// Byte-oriented SPI master with programmable CPOL/CPHA and sclk divider.
// Define SPI_MASTER_BURST_EN to let HOLD accept the next byte and chain
// transfers under a single ss assertion; otherwise ss drops between bytes.
module spi_master
    import spi_master_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter bit CPOL    = 1'b0,
    parameter bit CPHA    = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] txData,
    input  logic       txValid,
    output logic       txReady,
    output logic [7:0] rxData,
    output logic       rxValid,
    output logic       busy,
    input  logic       miso,
    output logic       mosi,
    output logic       sclk,
    output logic       ss
);
`ifdef SPI_MASTER_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    stateT       state, nextState;
    logic        tick, clkEn, accept, pending, rstDone, sclkR;
    logic        leadEdge, sampleEdge, shiftEdge, lastEdge;
    logic [3:0]  edgeCnt;
    logic [7:0]  txShift, rxShift;

    assign clkEn = (state != IDLE);

    spi_clk_gen #(.CLK_DIV(CLK_DIV)) uClkGen (
        .clk   (clk),
        .reset (reset),
        .en    (clkEn),
        .tick  (tick)
    );

    // rstDone holds txReady low until the first edge after reset.
    assign txReady = rstDone && (state == IDLE || (BURST && state == HOLD && !pending));
    assign accept  = txValid && txReady;
    assign busy    = (state != IDLE);
    assign ss      = (state == IDLE);
    assign sclk    = sclkR;
    assign mosi    = txShift[7];

    // Even edge index = leading edge. CPHA=1 skips the first leading shift
    // because bit 7 is already on mosi since the byte was loaded.
    assign leadEdge   = !edgeCnt[0];
    assign sampleEdge = (state == SHIFT) && tick && (leadEdge ^ CPHA);
    assign shiftEdge  = (state == SHIFT) && tick && !(leadEdge ^ CPHA)
                        && !(CPHA && edgeCnt == 4'd0);
    assign lastEdge   = (state == SHIFT) && tick && (edgeCnt == LAST_EDGE);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    // Next-state logic; every phase boundary lands on a divider tick.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (accept) nextState = SETUP;
            SETUP:   if (tick) nextState = SHIFT;
            SHIFT:   if (lastEdge) nextState = HOLD;
            HOLD:    if (tick) nextState = (pending || accept) ? SHIFT : IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Datapath: byte capture, sclk toggling, shift/sample and rx delivery.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rstDone <= 1'b0;
            pending <= 1'b0;
            sclkR   <= CPOL;
            edgeCnt <= '0;
            txShift <= '0;
            rxShift <= '0;
            rxData  <= '0;
            rxValid <= 1'b0;
        end else begin
            rstDone <= 1'b1;
            rxValid <= 1'b0;
            if (accept) txShift <= txData;
            // pending marks a chained byte; cleared as HOLD hands off.
            if (state == HOLD && tick) pending <= 1'b0;
            else if (accept)           pending <= (state == HOLD);
            if (state == SHIFT && tick) begin
                sclkR   <= ~sclkR;
                edgeCnt <= edgeCnt + 4'd1;
            end
            if (sampleEdge) rxShift <= {rxShift[6:0], miso};
            if (shiftEdge)  txShift <= {txShift[6:0], 1'b0};
            // With CPHA=1 the final sample coincides with the last edge.
            if (lastEdge) begin
                rxValid <= 1'b1;
                rxData  <= CPHA ? {rxShift[6:0], miso} : rxShift;
            end
        end
    end
endmodule

// File: tb/tb_spi_master.sv
// Randomized bench for spi_master: two instances (mode 0 / CLK_DIV 4 and
// mode 3 / CLK_DIV 3), an SPI slave model that shifts out a byte stream,
// and a bus monitor that rebuilds the serial bytes from sclk edges.
module tb_spi_master;
`ifdef SPI_MASTER_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif
    localparam bit [1:0] POL = 2'b10;
    localparam bit [1:0] PHA = 2'b10;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] txData [2];
    logic [7:0] rxData [2];
    logic [1:0] txValid, txReady, rxValid, busy, miso, mosi, sclk, ss, slvMiso;
    logic       loop0;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign miso[0] = loop0 ? mosi[0] : slvMiso[0];
    assign miso[1] = slvMiso[1];

    spi_master #(.CLK_DIV(4), .CPOL(1'b0), .CPHA(1'b0)) dut0 (
        .clk(clk), .reset(reset), .txData(txData[0]), .txValid(txValid[0]),
        .txReady(txReady[0]), .rxData(rxData[0]), .rxValid(rxValid[0]),
        .busy(busy[0]), .miso(miso[0]), .mosi(mosi[0]), .sclk(sclk[0]), .ss(ss[0]));

    spi_master #(.CLK_DIV(3), .CPOL(1'b1), .CPHA(1'b1)) dut1 (
        .clk(clk), .reset(reset), .txData(txData[1]), .txValid(txValid[1]),
        .txReady(txReady[1]), .rxData(rxData[1]), .rxValid(rxValid[1]),
        .busy(busy[1]), .miso(miso[1]), .mosi(mosi[1]), .sclk(sclk[1]), .ss(ss[1]));

    function automatic int divOf(input int d);
        return (d == 0) ? 4 : 3;
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Send n (1..2) bytes on DUT d with txValid held across them; slave
    // answers with s0/s1 unless loop (dut0 only) ties miso to mosi.
    task automatic xfer(input int d, input int n, input logic [7:0] t0, input logic [7:0] t1,
                        input logic [7:0] s0, input logic [7:0] s1, input bit loop, input string tag);
        logic [7:0]  txb [2];
        logic [7:0]  slb [2];
        logic [7:0]  rxGot [2];
        logic [15:0] mosiBits;
        int accCyc [2];
        int rxCyc [2];
        bit accBusy [2];
        int nAcc, nRx, nSamp, nLead, ssEdges, mosiBad, ssHighMid, ssRise, budget, armCyc, div;
        bit armed, armBusy, prevSclk, prevMosi, done, lead, samp, cpol, cpha;
        txb[0] = t0; txb[1] = t1; slb[0] = s0; slb[1] = s1;
        div = divOf(d); cpol = POL[d]; cpha = PHA[d];
        nAcc = 0; nRx = 0; nSamp = 0; nLead = 0; ssEdges = 0; mosiBad = 0; ssHighMid = 0;
        ssRise = -1; budget = 0; done = 0; mosiBits = '0;
        rxGot[0] = '0; rxGot[1] = '0; rxCyc[0] = 0; rxCyc[1] = 0;
        accCyc[0] = 0; accCyc[1] = 0; accBusy[0] = 0; accBusy[1] = 0;
        if (d == 0) loop0 = loop;
        @(negedge clk);
        check({tag, ".idleSclk"}, int'(sclk[d]), int'(cpol));
        prevSclk = sclk[d]; prevMosi = mosi[d];
        slvMiso[d] = slb[0][7];
        txData[d] = txb[0]; txValid[d] = 1'b1;
        armed = txReady[d]; armCyc = cyc; armBusy = busy[d];
        while (!done && budget < 40 * div + 60) begin
            budget++;
            @(negedge clk);
            if (armed) begin
                accCyc[nAcc] = armCyc; accBusy[nAcc] = armBusy; nAcc++;
                if (nAcc < n) txData[d] = txb[nAcc];
                else txValid[d] = 1'b0;
            end
            if (!txValid[d]) txData[d] = 8'($urandom);
            if (sclk[d] != prevSclk) begin
                lead = (sclk[d] != cpol);
                samp = lead ^ cpha;
                if (lead) nLead++;
                if (ss[d]) ssEdges++;
                if (samp) begin
                    if (mosi[d] != prevMosi) mosiBad++;
                    mosiBits = {mosiBits[14:0], mosi[d]};
                    nSamp++;
                    if (nSamp / 8 < n) slvMiso[d] = slb[nSamp / 8][7 - nSamp % 8];
                    else slvMiso[d] = 1'b0;
                end
            end
            if (rxValid[d]) begin
                if (nRx < 2) begin rxGot[nRx] = rxData[d]; rxCyc[nRx] = cyc; end
                nRx++;
            end
            if (nAcc > 0 && nRx < n && ss[d]) ssHighMid++;
            if (nRx == n && ss[d] && ssRise < 0) ssRise = cyc;
            prevSclk = sclk[d]; prevMosi = mosi[d];
            armed = txValid[d] && txReady[d]; armCyc = cyc; armBusy = busy[d];
            if (nAcc == n && nRx >= n && !busy[d]) done = 1;
        end
        check({tag, ".done"}, int'(done), 1);
        check({tag, ".rxCount"}, nRx, n);
        check({tag, ".leadEdges"}, nLead, 8 * n);
        check({tag, ".mosiOnSample"}, mosiBad, 0);
        check({tag, ".edgeSsHigh"}, ssEdges, 0);
        check({tag, ".rx0"}, int'(rxGot[0]), int'(loop ? txb[0] : slb[0]));
        check({tag, ".lat0"}, rxCyc[0] - accCyc[0], 17 * div + 1);
        if (n == 1) begin
            check({tag, ".mosi"}, int'(mosiBits[7:0]), int'(txb[0]));
        end else begin
            check({tag, ".mosi"}, int'(mosiBits), int'({txb[0], txb[1]}));
            check({tag, ".rx1"}, int'(rxGot[1]), int'(loop ? txb[1] : slb[1]));
            check({tag, ".acc1Busy"}, int'(accBusy[1]), int'(BURST));
            check({tag, ".ssGap"}, int'(ssHighMid > 0), int'(!BURST));
            if (BURST) check({tag, ".lat1"}, rxCyc[1] - rxCyc[0], 17 * div);
            else       check({tag, ".lat1"}, rxCyc[1] - accCyc[1], 17 * div + 1);
        end
        check({tag, ".ssRise"}, ssRise - rxCyc[n-1], div);
        check({tag, ".endSclk"}, int'(sclk[d]), int'(cpol));
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, ".ss0"}, int'(ss[0]), 1);
        check({tag, ".sclk0"}, int'(sclk[0]), 0);
        check({tag, ".mosi0"}, int'(mosi[0]), 0);
        check({tag, ".rxData0"}, int'(rxData[0]), 0);
        check({tag, ".rxValid0"}, int'(rxValid[0]), 0);
        check({tag, ".busy0"}, int'(busy[0]), 0);
        check({tag, ".txReady0"}, int'(txReady[0]), 0);
        check({tag, ".ss1"}, int'(ss[1]), 1);
        check({tag, ".sclk1"}, int'(sclk[1]), 1);
        check({tag, ".txReady1"}, int'(txReady[1]), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rxSeen;
        logic [7:0] a, b, c, e;
        int n, d;
        reset = 1'b1; loop0 = 1'b0; slvMiso = '0; txValid = '0;
        txData[0] = '0; txData[1] = '0;
        #3;
        checkResetOutputs("por");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("por.readyLow", int'(txReady[0]), 0);
        @(posedge clk); #1;
        check("por.readyHigh", int'(txReady[0]), 1);

        xfer(0, 1, 8'hA5, 8'h00, 8'h00, 8'h00, 1'b1, "m0A5");
        xfer(1, 1, 8'h3C, 8'h00, 8'hFF, 8'hFF, 1'b0, "m3x3C");
        xfer(0, 2, 8'h01, 8'h02, 8'h00, 8'h00, 1'b1, "burst0");
        xfer(1, 2, 8'h5A, 8'hC3, 8'h96, 8'h2D, 1'b0, "burst3");

        for (int i = 0; i < 8; i++) begin
            d = i % 2; n = 1 + int'($urandom_range(1));
            a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); e = 8'($urandom);
            xfer(d, n, a, b, c, e, (d == 0) && $urandom_range(1) == 1, $sformatf("rnd%0d", i));
        end

        // Abort 0xF0 mid-byte with an asynchronous reset.
        loop0 = 1'b1;
        @(negedge clk);
        txData[0] = 8'hF0; txValid[0] = 1'b1;
        @(negedge clk);
        txValid[0] = 1'b0;
        repeat (4 + 8 * 4) @(negedge clk);
        check("abort.busyBefore", int'(busy[0]), 1);
        #2 reset = 1'b1;
        #1;
        checkResetOutputs("abort");
        rxSeen = 0;
        repeat (3) begin
            @(negedge clk);
            if (rxValid[0]) rxSeen++;
        end
        reset = 1'b0;
        check("abort.readyLow", int'(txReady[0]), 0);
        @(posedge clk); #1;
        check("abort.readyHigh", int'(txReady[0]), 1);
        repeat (80) begin
            @(negedge clk);
            if (rxValid[0] || busy[0]) rxSeen++;
        end
        check("abort.noRxValid", rxSeen, 0);
        xfer(0, 1, 8'h81, 8'h00, 8'h00, 8'h00, 1'b1, "after81");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
